// File: rtl/rwm_frame_buffer.sv
// Interleaved multi-channel frame memory with a valid/ready write port and a valid/ready read port carrying channel/last tags.
// Optional zero sweep via RWM_FRAME_CLEAR_EN; each operation takes DEPTH cycles plus stalls, then done pulses for one cycle.
module rwm_frame_buffer #(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 5,
  parameter int IMG_H    = 5,
  parameter int CHANNELS = 3,
  localparam int DEPTH   = IMG_W * IMG_H * CHANNELS,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              rw_i,
  input  logic              clear_i,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CHAN_W-1:0] rd_chan_o,
  output logic              rd_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

`ifdef RWM_FRAME_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_READ = 2'd2, ST_CLEAR = 2'd3} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_READ = 2'd2} state_e;
  logic unused_clear;
  assign unused_clear = clear_i;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      chan_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      chan_q  <= chan_d;
      done_q  <= done_d;
    end
  end

  // Memory is deliberately left out of reset so a mid-operation reset preserves stored words.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[addr_q] <= mem_wdat;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    chan_d  = chan_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        chan_d = '0;
        if (enable_i) begin
`ifdef RWM_FRAME_CLEAR_EN
          if (clear_i)   state_d = ST_CLEAR;
          else if (rw_i) state_d = ST_WRITE;
          else           state_d = ST_READ;
`else
          if (rw_i) state_d = ST_WRITE;
          else      state_d = ST_READ;
`endif
        end
      end
      ST_WRITE: begin
        if (wr_valid_i) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rd_ready_i) begin
          chan_d = (chan_q == LAST_CHAN) ? '0 : chan_q + 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            chan_d  = '0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
`ifdef RWM_FRAME_CLEAR_EN
      ST_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        chan_d  = '0;
      end
    endcase
  end

  always_comb begin
    wr_ready_o = 1'b0;
    rd_valid_o = 1'b0;
    rd_data_o  = '0;
    rd_chan_o  = '0;
    rd_last_o  = 1'b0;
    mem_we     = 1'b0;
    mem_wdat   = wr_data_i;
    case (state_q)
      ST_WRITE: begin
        wr_ready_o = 1'b1;
        mem_we     = wr_valid_i;
      end
      ST_READ: begin
        rd_valid_o = 1'b1;
        rd_data_o  = mem_q[addr_q];
        rd_chan_o  = chan_q;
        rd_last_o  = (addr_q == LAST_ADDR);
      end
`ifdef RWM_FRAME_CLEAR_EN
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_wdat = '0;
      end
`endif
      default: ;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;

endmodule

// File: doc/rwm_frame_buffer.md
# rwm_frame_buffer

Parametrised read/write frame memory holding one interleaved multi-channel image (default 5x5 RGB, 8-bit samples) between the camera front end and the grayscaling stage. Commands from the controller select write, read or clear. Write and read transfers use valid/ready handshakes, so the camera and the grayscaler can stall the block on any cycle. Streamed reads carry channel and end-of-frame tags.

## Interface
- DATA_W, 8, sample width in bits
- IMG_W, 5, image width in pixels
- IMG_H, 5, image height in pixels
- CHANNELS, 3, samples per pixel, interleaved (R,G,B order for 3)
- DEPTH, IMG_W*IMG_H*CHANNELS, derived; words stored
- ADDR_W, $clog2(DEPTH), derived; address/counter width
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  command strobe from controller, sampled only in IDLE
- rw  input  1  1 = write frame, 0 = read frame
- clear  input  1  1 = clear frame (priority over rw)
- wr_valid  input  1  camera has a sample on wr_data
- wr_data  input  DATA_W  sample from camera
- wr_ready  output  1  block accepts wr_data this cycle
- rd_ready  input  1  grayscaler accepts rd_data this cycle (replaces pause)
- rd_valid  output  1  rd_data holds a stored sample
- rd_data  output  DATA_W  sample at current address; 0 when rd_valid=0
- rd_chan  output  $clog2(CHANNELS)  channel index of rd_data (0..CHANNELS-1)
- rd_last  output  1  rd_data is word DEPTH-1
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse, operation completed

## Operation
- States: IDLE, WRITE, READ, CLEAR. Registers: state, addr (ADDR_W), chan (channel counter), done.
- IDLE: addr=0, chan=0. If enable=1: clear=1 -> CLEAR, else rw=1 -> WRITE, else READ. enable=0 -> stay.
- WRITE: wr_ready=1. Transfer when wr_valid&wr_ready: mem[addr]<=wr_data, addr++. If wr_valid=0, addr holds (stall). Transfer at addr=DEPTH-1 -> IDLE, done=1 next cycle.
- READ: rd_valid=1, rd_data=mem[addr] (asynchronous read), rd_chan=chan, rd_last=(addr==DEPTH-1). Transfer when rd_valid&rd_ready: addr++, chan wraps CHANNELS-1 -> 0. rd_ready=0 holds addr, rd_data, rd_chan stable. Final transfer -> IDLE, done=1 next cycle.
- CLEAR: mem[addr]<=0, addr++ every cycle, no handshake; DEPTH cycles. Write at DEPTH-1 -> IDLE, done=1 next cycle.
- enable, rw and clear are ignored outside IDLE. An operation always runs to completion unless rst is asserted.
- Memory contents are not reset. Reads of never-written, never-cleared words return undefined data.
- Illegal state encodings -> IDLE.

## Timing
- Reset values: state=IDLE, addr=0, chan=0. Outputs: wr_ready=0, rd_valid=0, rd_data=0, rd_chan=0, rd_last=0, busy=0, done=0.
- Command sampled in cycle C. The new state is active from C+1, when the first transfer can occur.
- Minimum operation length: DEPTH cycles after C. Each stall cycle adds one.
- done rises in the cycle after the final transfer, in IDLE, and lasts exactly 1 cycle.
- A new command may be accepted in the same cycle done=1 (back-to-back, zero idle gap).
- rst mid-operation: the next edge returns all registers to reset values. Words already written or cleared keep their values. No done pulse is produced.
- addr never exceeds DEPTH-1; the return to IDLE resets it to 0 (wrap).

## Configuration
- Macro RWM_FRAME_CLEAR_EN.
- Defined: the CLEAR state exists and clear=1 with enable=1 starts a DEPTH-cycle zero sweep.
- Undefined: no CLEAR state or zero-write logic. The clear input is ignored, and enable=1 dispatches on rw alone.

## Test plan
- Reset, then hold enable=0 for 10 cycles -> all outputs 0, busy=0, no done.
- Write 75 samples 0x00..0x4A with wr_valid always 1 -> done at cycle C+76. Read with rd_ready=1 -> 0x00..0x4A in order, rd_chan cycles 0,1,2, rd_last only on 0x4A, done once.
- Write with wr_valid toggling 1,0 -> wr_ready=1 throughout, 75 words stored, done at C+150. During a read, rd_ready=0 for 4 cycles at word 10 -> rd_data=0x0A and rd_chan=1 held, no skip or duplicate.
- With RWM_FRAME_CLEAR_EN: clear after write -> busy for 75 cycles, done. The following read returns 75 words of 0x00. Without the macro: the same stimulus with rw=0 performs a read of the original data.
- rst asserted at write word 40 -> outputs reset immediately, no done. A subsequent full read returns words 0..39 as written.
- A command on the done cycle (read immediately after write) -> READ starts with zero gap; rw and clear toggled during READ have no effect.
